// File: rtl/jtkicker_sdram_arb.sv
// jtkicker_sdram_arb: four-slot ROM read arbiter in front of the SDRAM read port.
// Each slot keeps a one-word cache (address + data); slot 0 has absolute priority,
// slots 1-3 rotate round-robin. Define JTKICKER_ARB_STATS_EN to add per-slot
// saturating grant counters readable through debug_sel/debug_view.
module jtkicker_sdram_arb #(
    parameter int          AW      = 16,
    parameter logic [21:0] OFFSET0 = 22'h0,
    parameter logic [21:0] OFFSET1 = 22'h0,
    parameter logic [21:0] OFFSET2 = 22'h0,
    parameter logic [21:0] OFFSET3 = 22'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            downloading,
    input  logic [3:0]      slot_cs,
    input  logic [4*AW-1:0] slot_addr,
    output logic [3:0]      slot_ok,
    output logic [63:0]     slot_dout,
    output logic            sdram_req,
    output logic [21:0]     sdram_addr,
    input  logic            sdram_ack,
    input  logic            data_rdy,
    input  logic [15:0]     data_read
`ifdef JTKICKER_ARB_STATS_EN
    ,
    input  logic [1:0]      debug_sel,
    output logic [7:0]      debug_view
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [3:0][21:0] OFFS = {OFFSET3, OFFSET2, OFFSET1, OFFSET0};

    logic [1:0]           state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [AW-1:0]        faddr_q, faddr_d;
    logic                 req_q, req_d;
    logic [21:0]          saddr_q, saddr_d;
    logic [3:0]           valid_q, valid_d;
    logic [3:0][AW-1:0]   cached_q, cached_d;
    logic [3:0][15:0]     dout_q, dout_d;

    logic [3:0][AW-1:0]   addr_a;
    logic [3:0]           hit, need;
    logic [1:0]           sel;
    logic                 issue;

    assign addr_a     = slot_addr;
    assign sdram_req  = req_q;
    assign sdram_addr = saddr_q;
    assign slot_dout  = dout_q;
    assign issue      = (state_q == ST_IDLE) && !downloading && (|need);

    // Cache lookup: hit/need per slot, ok is combinational on the live request
    always_comb begin
        hit = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            hit[n] = valid_q[n] && (cached_q[n] == addr_a[n]);
        end
        need    = slot_cs & ~hit;
        slot_ok = slot_cs & hit;
    end

    // Grant choice: slot 0 first, else first needy slot after the pointer among 1-3
    always_comb begin
        int unsigned c;
        logic [1:0]  cand;
        logic        found;
        sel   = 2'd0;
        found = need[0];
        c     = 0;
        cand  = 2'd0;
        for (int unsigned k = 1; k <= 3; k++) begin
            c = 32'(ptr_q) + k;
            if (c > 3) c = c - 3;
            cand = 2'(c);
            if (!found && need[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // Next-state logic for the IDLE -> REQ -> WAIT fetch sequence and the caches
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        faddr_d  = faddr_q;
        req_d    = req_q;
        saddr_d  = saddr_q;
        valid_d  = valid_q;
        cached_d = cached_q;
        dout_d   = dout_q;
        if (downloading) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            valid_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        gnt_d   = sel;
                        faddr_d = addr_a[sel];
                        saddr_d = 22'(addr_a[sel]) + OFFS[sel];
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        req_d   = 1'b0;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        dout_d[gnt_q]   = data_read;
                        cached_d[gnt_q] = faddr_q;
                        valid_d[gnt_q]  = 1'b1;
                        if (gnt_q != 2'd0) ptr_d = gnt_q;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 2'd0;
            ptr_q    <= 2'd3;
            faddr_q  <= '0;
            req_q    <= 1'b0;
            saddr_q  <= '0;
            valid_q  <= '0;
            cached_q <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            faddr_q  <= faddr_d;
            req_q    <= req_d;
            saddr_q  <= saddr_d;
            valid_q  <= valid_d;
            cached_q <= cached_d;
            dout_q   <= dout_d;
        end
    end

`ifdef JTKICKER_ARB_STATS_EN
    logic [3:0][7:0] cnt_q;
    logic            dl_q;
    logic [7:0]      view_q;

    assign debug_view = view_q;

    // Saturating grant counters, cleared when a download starts; registered readback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dl_q   <= 1'b0;
            view_q <= '0;
        end else begin
            dl_q   <= downloading;
            view_q <= cnt_q[debug_sel];
            if (downloading && !dl_q) begin
                cnt_q <= '0;
            end else if (issue && cnt_q[sel] != 8'hFF) begin
                cnt_q[sel] <= cnt_q[sel] + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jtkicker_sdram_arb.sv
// Testbench for jtkicker_sdram_arb: the bench plays the SDRAM controller and keeps a
// transaction-level model of the slot caches, grant order and fetch progress.
module tb_jtkicker_sdram_arb;

    localparam int          AW   = 16;
    localparam logic [21:0] OFF0 = 22'h000000;
    localparam logic [21:0] OFF1 = 22'h010000;
    localparam logic [21:0] OFF2 = 22'h020000;
    localparam logic [21:0] OFF3 = 22'h3F8000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dl;
    logic [3:0]  cs;
    logic [15:0] a [4];
    logic        ack, rdy;
    logic [15:0] rd;
    logic [1:0]  dsel;

    logic [4*AW-1:0] slot_addr;
    logic [3:0]      slot_ok;
    logic [63:0]     slot_dout;
    logic [3:0][15:0] dv;
    logic            sdram_req;
    logic [21:0]     sdram_addr;
    logic [7:0]      debug_view;

    assign slot_addr = {a[3], a[2], a[1], a[0]};
    assign dv        = slot_dout;

    always #10 clk = ~clk;

    jtkicker_sdram_arb #(
        .AW(AW), .OFFSET0(OFF0), .OFFSET1(OFF1), .OFFSET2(OFF2), .OFFSET3(OFF3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .downloading(dl),
        .slot_cs(cs), .slot_addr(slot_addr),
        .slot_ok(slot_ok), .slot_dout(slot_dout),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(ack), .data_rdy(rdy), .data_read(rd)
`ifdef JTKICKER_ARB_STATS_EN
        , .debug_sel(dsel), .debug_view(debug_view)
`endif
    );

`ifndef JTKICKER_ARB_STATS_EN
    assign debug_view = 8'h00;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 no fetch outstanding, 1 request posted, 2 accepted, awaiting data
    int          m_phase, m_g, m_ptr;
    logic [15:0] m_faddr;
    logic [21:0] m_saddr;
    bit          m_valid [4];
    logic [15:0] m_caddr [4];
    logic [15:0] m_data  [4];
    int          m_cnt   [4];
    int          m_view;
    bit          m_dl_prev;
    int          mode;

    function automatic logic [21:0] off_of(int n);
        case (n)
            0: return OFF0;
            1: return OFF1;
            2: return OFF2;
            default: return OFF3;
        endcase
    endfunction

    function automatic bit m_hit(int n);
        return m_valid[n] && (m_caddr[n] == a[n]);
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_g = 0; m_ptr = 3; m_faddr = '0; m_saddr = '0;
        m_view = 0; m_dl_prev = 0;
        for (int n = 0; n < 4; n++) begin
            m_valid[n] = 0; m_caddr[n] = '0; m_data[n] = '0; m_cnt[n] = 0;
        end
    endfunction

    // Applies one clock edge worth of the specified behaviour to the model
    function automatic void model_step();
        bit needy [4];
        int g;
        m_view = m_cnt[dsel];
        if (dl && !m_dl_prev) for (int n = 0; n < 4; n++) m_cnt[n] = 0;
        m_dl_prev = dl;
        if (dl) begin
            m_phase = 0;
            for (int n = 0; n < 4; n++) m_valid[n] = 0;
            return;
        end
        if (m_phase == 0) begin
            for (int n = 0; n < 4; n++) needy[n] = cs[n] && !m_hit(n);
            g = -1;
            if (needy[0]) g = 0;
            else
                for (int k = 1; k <= 3; k++) begin
                    int c = (m_ptr - 1 + k) % 3 + 1;
                    if (g < 0 && needy[c]) g = c;
                end
            if (g >= 0) begin
                m_g = g;
                m_faddr = a[g];
                m_saddr = ({6'd0, a[g]} + off_of(g)) % (1 << 22);
                m_phase = 1;
                if (m_cnt[g] < 255) m_cnt[g]++;
            end
        end else if (m_phase == 1) begin
            if (ack) m_phase = 2;
        end else begin
            if (rdy) begin
                m_data[m_g]  = rd;
                m_caddr[m_g] = m_faddr;
                m_valid[m_g] = 1;
                if (m_g != 0) m_ptr = m_g;
                m_phase = 0;
            end
        end
    endfunction

    task automatic check_all();
        logic [3:0] exp_ok;
        for (int n = 0; n < 4; n++) exp_ok[n] = cs[n] && m_hit(n);
        chk("req", 32'(sdram_req), 32'(m_phase == 1));
        chk("addr", 32'(sdram_addr), 32'(m_saddr));
        chk("ok", 32'(slot_ok), 32'(exp_ok));
        for (int n = 0; n < 4; n++)
            chk($sformatf("dout%0d", n), 32'(dv[2'(n)]), 32'(m_data[n]));
`ifdef JTKICKER_ARB_STATS_EN
        chk("view", 32'(debug_view), 32'(m_view));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        model_step();
        check_all();
    endtask

    // Chooses next-cycle inputs; the bench acts as the SDRAM controller
    task automatic drive();
        if (mode == 0) begin
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(0, 9) == 0) cs[n] = ~cs[n];
                if ($urandom_range(0, 7) == 0) a[n] = 16'hA000 + 16'($urandom_range(0, 3)) * 16'h0111;
            end
            ack  = sdram_req && ($urandom_range(0, 2) == 0);
            rdy  = (m_phase == 2 && $urandom_range(0, 2) == 0) || (m_phase == 0 && $urandom_range(0, 9) == 0);
            dl   = ($urandom_range(0, 79) == 0);
            dsel = 2'($urandom_range(0, 3));
        end else begin
            cs   = 4'b0010;
            a[1] = a[1] + 16'd1;
            ack  = sdram_req;
            rdy  = (m_phase == 2);
            dl   = 1'b0;
            dsel = 2'd1;
        end
        rd = 16'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; dl = 1'b0; cs = 4'hF; ack = 1'b0; rdy = 1'b0; rd = '0; dsel = 2'd0;
        for (int n = 0; n < 4; n++) a[n] = 16'hA000;
        mode = 0;
        model_reset();
        #25;
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        chk("rst_ok", 32'(slot_ok), 32'd0);
        chk("rst_dout", slot_dout[31:0] | slot_dout[63:32], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cs = 4'b0001;
        a[0] = 16'h1234;

        // Single miss on slot 0, then a hit on the same address
        step();
        chk("t1_req", 32'(sdram_req), 32'd1);
        chk("t1_addr", 32'(sdram_addr), 32'h001234);
        ack = 1'b1;
        step();
        ack = 1'b0; rdy = 1'b1; rd = 16'hBEEF;
        step();
        chk("t1_ok", 32'(slot_ok[0]), 32'd1);
        chk("t1_dout", 32'(dv[0]), 32'hBEEF);
        rdy = 1'b0;
        step();
        chk("t2_req", 32'(sdram_req), 32'd0);
        chk("t2_ok", 32'(slot_ok[0]), 32'd1);

        // Randomized traffic with address changes, cs drops and download pulses
        for (int i = 0; i < 4000; i++) begin
            drive();
            step();
        end

`ifdef JTKICKER_ARB_STATS_EN
        mode = 1;
        dl = 1'b0;
        begin
            int cyc = 0;
            while (m_cnt[1] < 255 && cyc < 2000) begin
                drive();
                step();
                cyc++;
            end
            repeat (310 * 3 - cyc > 0 ? 310 * 3 - cyc : 3) begin
                drive();
                step();
            end
        end
        chk("stat_sat", 32'(debug_view), 32'hFF);
        cs = 4'b0000; ack = 1'b0; rdy = 1'b0; dl = 1'b1;
        step();
        dl = 1'b0;
        step();
        step();
        chk("stat_clr", 32'(debug_view), 32'h00);
        mode = 0;
`endif

        // Asynchronous reset in the middle of a fetch
        begin
            int cyc = 0;
            dl = 1'b0;
            while (m_phase == 0 && cyc < 200) begin
                drive();
                dl = 1'b0;
                step();
                cyc++;
            end
            chk("mid_fetch_reached", 32'(m_phase != 0), 32'd1);
        end
        #3 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(sdram_req), 32'd0);
        chk("arst_addr", 32'(sdram_addr), 32'd0);
        chk("arst_ok", 32'(slot_ok), 32'd0);
        chk("arst_dout", slot_dout[31:0] | slot_dout[63:32], 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
